// File: rtl/reg_lock_scbd_if.sv
// Issue/writeback/status bundle between decode and the register lock scoreboard.
// The scoreboard takes the slave modport; the decode side takes the master modport.
interface reg_lock_scbd_if #(
  parameter int unsigned NR = 64,
  parameter int unsigned NI = 2,
  parameter int unsigned NW = 2
);
  localparam int unsigned RW = $clog2(NR);
  localparam int unsigned CW = $clog2(NR + 1);

  logic [NI-1:0]          issue_valid_i;
  logic [NI-1:0]          issue_jump_i;
  logic [NI-1:0][RW-1:0]  issue_rd_i;
  logic [NI-1:0][NR-1:0]  issue_req_i;
  logic [NI-1:0]          issue_gnt_o;
  logic [NW-1:0]          wb_valid_i;
  logic [NW-1:0][RW-1:0]  wb_rd_i;
  logic                   flush_done_i;
  logic [NR-1:0]          locks_o;
  logic [CW-1:0]          lock_cnt_o;
  logic                   in_jump_o;
  logic                   wb_err_o;

  modport master (
    output issue_valid_i, issue_jump_i, issue_rd_i, issue_req_i,
    output wb_valid_i, wb_rd_i, flush_done_i,
    input  issue_gnt_o, locks_o, lock_cnt_o, in_jump_o, wb_err_o
  );

  modport slave (
    input  issue_valid_i, issue_jump_i, issue_rd_i, issue_req_i,
    input  wb_valid_i, wb_rd_i, flush_done_i,
    output issue_gnt_o, locks_o, lock_cnt_o, in_jump_o, wb_err_o
  );
endinterface

// File: rtl/reg_lock_scbd.sv
// Register lock scoreboard: in-order multi-issue grant against an internal lock bitmap,
// with writeback bypass, intra-bundle hazard checks and a jump/flush lock-all state.
module reg_lock_scbd #(
  parameter int unsigned NR           = 64,
  parameter int unsigned NI           = 2,
  parameter int unsigned NW           = 2,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  reg_lock_scbd_if.slave  bus
);
  localparam int unsigned RW = $clog2(NR);
  localparam int unsigned CW = $clog2(NR + 1);

  typedef enum logic [0:0] {StRun, StJump} state_e;

  state_e        state_q, state_d;
  logic [NR-1:0] locks_q, locks_d;
  logic          wb_err_q, wb_err_d;

  logic [NR-1:0] keep_mask;
  logic [NR-1:0] wb_mask;
  logic [NR-1:0] eff_locks;
  logic [NR-1:0] bundle_rd;
  logic [NR-1:0] need;
  logic [NI-1:0] gnt;
  logic          run;
  logic          open;
  logic          jump_gnt;
  logic          wb_hit_free;
  logic [CW-1:0] cnt;

  function automatic logic [NR-1:0] onehot(input logic [RW-1:0] idx);
    logic [NR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    keep_mask = '1;
    if (R0_HARDWIRED) keep_mask[0] = 1'b0;
    run = (state_q == StRun);

    // Writebacks only matter in RUN; in JUMP everything stays locked until flush.
    wb_mask     = '0;
    wb_hit_free = 1'b0;
    if (run) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (bus.wb_valid_i[w]) begin
          wb_mask = wb_mask | onehot(bus.wb_rd_i[w]);
          if (keep_mask[bus.wb_rd_i[w]] && !locks_q[bus.wb_rd_i[w]]) wb_hit_free = 1'b1;
        end
      end
    end
    wb_mask   = wb_mask & keep_mask;
    eff_locks = locks_q & ~wb_mask;

    // In-order grant: the first stall or granted jump closes the bundle.
    bundle_rd = '0;
    gnt       = '0;
    jump_gnt  = 1'b0;
    need      = '0;
    open      = run & ~arst_i;
    for (int unsigned k = 0; k < NI; k++) begin
      need = (bus.issue_req_i[k] | onehot(bus.issue_rd_i[k])) & keep_mask;
      if (open && bus.issue_valid_i[k] && ((need & (eff_locks | bundle_rd)) == '0)) begin
        gnt[k]    = 1'b1;
        bundle_rd = bundle_rd | onehot(bus.issue_rd_i[k]);
        if (bus.issue_jump_i[k]) begin
          jump_gnt = 1'b1;
          open     = 1'b0;
        end
      end else begin
        open = 1'b0;
      end
    end

    state_d  = state_q;
    locks_d  = locks_q;
    wb_err_d = wb_err_q | wb_hit_free;
    unique case (state_q)
      StRun: begin
        if (jump_gnt) begin
          locks_d = keep_mask;
          state_d = StJump;
        end else begin
          locks_d = eff_locks | (bundle_rd & keep_mask);
        end
      end
      StJump: begin
        if (bus.flush_done_i) begin
          locks_d = '0;
          state_d = StRun;
        end
      end
    endcase

    cnt = '0;
    for (int unsigned i = 0; i < NR; i++) cnt = cnt + CW'(locks_q[i]);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= StRun;
      locks_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locks_q  <= locks_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign bus.issue_gnt_o = gnt;
  assign bus.locks_o     = locks_q;
  assign bus.lock_cnt_o  = cnt;
  assign bus.in_jump_o   = (state_q == StJump);
  assign bus.wb_err_o    = wb_err_q;
endmodule
